// File: rtl/pe_config_sequencer.sv
// Streams (address, data) configuration writes from a valid/ready word stream onto the PE config bus.
// Optional trailer checksum over header/addr/data words: define PE_CONFIG_SEQ_CHECKSUM_EN.
module pe_config_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 1024,
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] writes_done
);

  typedef enum logic [3:0] {
    StIdle, StHdr, StAddr, StData, StWrite, StGap, StDone, StErr
`ifdef PE_CONFIG_SEQ_CHECKSUM_EN
    , StChk
`endif
  } state_e;

`ifdef PE_CONFIG_SEQ_CHECKSUM_EN
  localparam state_e StEnd = StChk;
`else
  localparam state_e StEnd = StDone;
`endif

  localparam logic [7:0] HoldInit = 8'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] remaining_q;
  logic [31:0] addr_q;
  logic [7:0]  hold_q;
  logic [31:0] wait_q;
  logic        fetch, accept, launch, timeout_hit;
`ifdef PE_CONFIG_SEQ_CHECKSUM_EN
  logic [31:0] acc_q;
`endif

  always_comb begin
    fetch = (state_q == StHdr) || (state_q == StAddr) || (state_q == StData);
`ifdef PE_CONFIG_SEQ_CHECKSUM_EN
    fetch = fetch || (state_q == StChk);
`endif
    accept      = fetch && in_valid;
    launch      = start && ((state_q == StIdle) || (state_q == StErr));
    timeout_hit = (TIMEOUT != 0) && fetch && !in_valid && (wait_q == 32'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StHdr;
      StHdr: begin
        if (timeout_hit)   state_d = StErr;
        else if (in_valid) state_d = (in_data[15:0] == 16'd0) ? StEnd : StAddr;
      end
      StAddr: begin
        // Unit select 0 would address no tile unit: treat as a corrupt stream.
        if (timeout_hit)   state_d = StErr;
        else if (in_valid) state_d = (in_data[31:16] == 16'd0) ? StErr : StData;
      end
      StData: begin
        if (timeout_hit)   state_d = StErr;
        else if (in_valid) state_d = StWrite;
      end
      StWrite: if (hold_q == 8'd0) state_d = StGap;
      StGap:   state_d = (remaining_q == 16'd1) ? StEnd : StAddr;
      StDone:  state_d = StIdle;
      StErr:   if (start) state_d = StHdr;
`ifdef PE_CONFIG_SEQ_CHECKSUM_EN
      StChk: begin
        if (timeout_hit)   state_d = StErr;
        else if (in_valid) state_d = (in_data == acc_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = fetch;
    busy     = !((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
    done     = (state_q == StDone);
    error    = (state_q == StErr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining_q <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      wait_q      <= '0;
      writes_done <= '0;
      config_addr <= IDLE_ADDR;
      config_data <= '0;
    end else begin
      wait_q <= (fetch && !in_valid) ? wait_q + 32'd1 : 32'd0;
      if (launch) writes_done <= '0;
      if (accept && (state_q == StHdr))  remaining_q <= in_data[15:0];
      if (accept && (state_q == StAddr)) addr_q <= in_data;
      if (accept && (state_q == StData))                hold_q <= HoldInit;
      else if ((state_q == StWrite) && (hold_q != 8'd0)) hold_q <= hold_q - 8'd1;
      if (state_q == StGap) begin
        remaining_q <= remaining_q - 16'd1;
        if (writes_done != 16'hFFFF) writes_done <= writes_done + 16'd1;
      end
      // Bus is registered: load it on the edge that enters WRITE, drop it on the edge leaving.
      if (state_d == StWrite) begin
        config_addr <= addr_q;
        config_data <= (state_q == StData) ? in_data : config_data;
      end else begin
        config_addr <= IDLE_ADDR;
        config_data <= '0;
      end
    end
  end

`ifdef PE_CONFIG_SEQ_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              acc_q <= '0;
    else if (launch)                        acc_q <= '0;
    else if (accept && (state_q != StChk))  acc_q <= acc_q ^ in_data;
  end
`endif

endmodule

// File: tb/tb_pe_config_sequencer.sv
// Directed bench for pe_config_sequencer: one DUT with HOLD_CYCLES=1, one with HOLD_CYCLES=3.
// Both use TIMEOUT=16; checksum scenarios run when PE_CONFIG_SEQ_CHECKSUM_EN is defined.
module tb_pe_config_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st   [2];
  logic        vld  [2];
  logic [31:0] din  [2];
  logic        rdy  [2];
  logic [31:0] cfg_addr [2];
  logic [31:0] cfg_data [2];
  logic        bsy  [2];
  logic        dn   [2];
  logic        err  [2];
  logic [15:0] wd   [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] wq [$];

  // Bus monitor: each contiguous non-idle stretch on config_addr is one recorded write.
  logic [31:0] run_addr [2][8];
  logic [31:0] run_data [2][8];
  int          run_len  [2][8];
  int          nrun     [2];
  int          ndone    [2];
  int          rdy_bad  [2];
  logic [31:0] prev_addr [2];

  always #5 clk = ~clk;

  pe_config_sequencer #(.HOLD_CYCLES(1), .TIMEOUT(16)) dut0 (
    .clk(clk), .reset(rst), .start(st[0]), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .config_addr(cfg_addr[0]), .config_data(cfg_data[0]),
    .busy(bsy[0]), .done(dn[0]), .error(err[0]), .writes_done(wd[0])
  );

  pe_config_sequencer #(.HOLD_CYCLES(3), .TIMEOUT(16)) dut1 (
    .clk(clk), .reset(rst), .start(st[1]), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .config_addr(cfg_addr[1]), .config_data(cfg_data[1]),
    .busy(bsy[1]), .done(dn[1]), .error(err[1]), .writes_done(wd[1])
  );

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cfg_addr[d] != 32'h0) begin
        if (prev_addr[d] == 32'h0) begin
          if (nrun[d] < 8) begin
            run_addr[d][nrun[d]] = cfg_addr[d];
            run_data[d][nrun[d]] = cfg_data[d];
            run_len[d][nrun[d]]  = 1;
            nrun[d]++;
          end
        end else if (nrun[d] > 0) begin
          run_len[d][nrun[d]-1]++;
        end
        if (rdy[d]) rdy_bad[d]++;
      end
      prev_addr[d] = cfg_addr[d];
      if (dn[d]) ndone[d]++;
    end
  end

  task automatic clear_log(input int d);
    nrun[d] = 0;
    ndone[d] = 0;
    rdy_bad[d] = 0;
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk) st[d] = 1'b1;
    @(negedge clk) st[d] = 1'b0;
  endtask

  task automatic add_trailer();
`ifdef PE_CONFIG_SEQ_CHECKSUM_EN
    logic [31:0] x = '0;
    foreach (wq[i]) x ^= wq[i];
    wq.push_back(x);
`endif
  endtask

  // Presents wq word by word; returns 1 time unit after the edge that accepted the last word.
  task automatic feed(input int d, input bit toggle);
    int idx = 0;
    int guard = 0;
    bit ph = 1'b0;
    bit acc;
    while (idx < wq.size() && guard < 400) begin
      @(negedge clk);
      ph = ~ph;
      vld[d] = toggle ? ph : 1'b1;
      din[d] = wq[idx];
      acc = vld[d] && rdy[d];
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    #1 vld[d] = 1'b0;
    checks++;
    if (idx != wq.size()) begin
      errors++;
      $display("FAIL feed_accept dut%0d: accepted %0d words, required %0d", d, idx, wq.size());
    end
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bsy[d] && n < 100);
    checks++;
    if (bsy[d]) begin
      errors++;
      $display("FAIL wait_idle dut%0d: busy still 1 after %0d cycles", d, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cfg_addr[d] !== 32'h0 || cfg_data[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_bus dut%0d: addr=%h data=%h, required 0/0", d, cfg_addr[d], cfg_data[d]);
      end
      checks++;
      if ({rdy[d], bsy[d], dn[d], err[d]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_flags dut%0d: ready/busy/done/error=%b, required 0000", d,
                 {rdy[d], bsy[d], dn[d], err[d]});
      end
      checks++;
      if (wd[d] !== 16'd0) begin
        errors++;
        $display("FAIL reset_writes dut%0d: got %0d, required 0", d, wd[d]);
      end
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic check_two_writes(input int d, input int len);
    checks++;
    if (nrun[d] != 2) begin
      errors++;
      $display("FAIL write_count dut%0d: got %0d bus writes, required 2", d, nrun[d]);
    end else begin
      checks++;
      if (run_addr[d][0] !== 32'h0007_0003 || run_data[d][0] !== 32'h0000_00A5) begin
        errors++;
        $display("FAIL write0 dut%0d: got %h/%h, required 00070003/000000a5", d,
                 run_addr[d][0], run_data[d][0]);
      end
      checks++;
      if (run_addr[d][1] !== 32'h0004_0003 || run_data[d][1] !== 32'h0000_0002) begin
        errors++;
        $display("FAIL write1 dut%0d: got %h/%h, required 00040003/00000002", d,
                 run_addr[d][1], run_data[d][1]);
      end
      checks++;
      if (run_len[d][0] != len || run_len[d][1] != len) begin
        errors++;
        $display("FAIL hold_len dut%0d: got %0d,%0d cycles, required %0d", d,
                 run_len[d][0], run_len[d][1], len);
      end
    end
    checks++;
    if (ndone[d] != 1) begin
      errors++;
      $display("FAIL done_pulses dut%0d: got %0d, required 1", d, ndone[d]);
    end
    checks++;
    if (wd[d] !== 16'd2 || err[d] !== 1'b0) begin
      errors++;
      $display("FAIL final_state dut%0d: writes_done=%0d error=%b, required 2/0", d, wd[d], err[d]);
    end
  endtask

  task automatic test_basic();
    clear_log(0);
    pulse_start(0);
    checks++;
    if (bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, required 1", bsy[0]);
    end
    wq = '{32'd2, 32'h0007_0003, 32'h0000_00A5, 32'h0004_0003, 32'h0000_0002};
    add_trailer();
    feed(0, 1'b0);
    wait_idle(0);
    check_two_writes(0, 1);
  endtask

  task automatic test_backpressure();
    clear_log(1);
    pulse_start(1);
    wq = '{32'd2, 32'h0007_0003, 32'h0000_00A5, 32'h0004_0003, 32'h0000_0002};
    add_trailer();
    feed(1, 1'b1);
    wait_idle(1);
    check_two_writes(1, 3);
    checks++;
    if (rdy_bad[1] != 0) begin
      errors++;
      $display("FAIL ready_during_write: in_ready high on %0d bus-write cycles, required 0",
               rdy_bad[1]);
    end
  endtask

  task automatic test_zero_header();
    clear_log(0);
    pulse_start(0);
    wq = '{32'd0};
    add_trailer();
    feed(0, 1'b0);
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_hdr_done: got %b one cycle after last accept, required 1", dn[0]);
    end
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_hdr_done_width: got %b on second cycle, required 0", dn[0]);
    end
    checks++;
    if (nrun[0] != 0 || wd[0] !== 16'd0 || ndone[0] != 1) begin
      errors++;
      $display("FAIL zero_hdr_result: writes=%0d writes_done=%0d done_pulses=%0d, required 0/0/1",
               nrun[0], wd[0], ndone[0]);
    end
  endtask

  task automatic test_bad_addr();
    clear_log(0);
    pulse_start(0);
    wq = '{32'd1, 32'h0000_0005};
    feed(0, 1'b0);
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr_error: error=%b busy=%b, required 1/0", err[0], bsy[0]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (nrun[0] != 0 || err[0] !== 1'b1) begin
      errors++;
      $display("FAIL bad_addr_sticky: writes=%0d error=%b, required 0/1", nrun[0], err[0]);
    end
    clear_log(0);
    pulse_start(0);
    checks++;
    if (err[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_clears: error=%b busy=%b, required 0/1", err[0], bsy[0]);
    end
    wq = '{32'd1, 32'h0005_0002, 32'h0000_0055};
    add_trailer();
    feed(0, 1'b0);
    wait_idle(0);
    checks++;
    if (nrun[0] != 1 || run_addr[0][0] !== 32'h0005_0002 || run_data[0][0] !== 32'h0000_0055 ||
        ndone[0] != 1 || wd[0] !== 16'd1) begin
      errors++;
      $display("FAIL restart_load: writes=%0d addr=%h data=%h done=%0d wd=%0d, required 1/00050002/55/1/1",
               nrun[0], run_addr[0][0], run_data[0][0], ndone[0], wd[0]);
    end
  endtask

  task automatic test_timeout();
    clear_log(0);
    pulse_start(0);
    wq = '{32'd1};
    feed(0, 1'b0);
    repeat (16) @(negedge clk);
    checks++;
    if (err[0] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: error=%b after 15 wait cycles, required 0", err[0]);
    end
    @(negedge clk);
    checks++;
    if (err[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: error=%b busy=%b after 16 wait cycles, required 1/0",
               err[0], bsy[0]);
    end
  endtask

  task automatic test_reset_mid_write();
    clear_log(1);
    pulse_start(1);
    wq = '{32'd1, 32'h0007_0001, 32'h0000_0077};
    feed(1, 1'b0);
    checks++;
    if (cfg_addr[1] !== 32'h0007_0001) begin
      errors++;
      $display("FAIL write_active: config_addr=%h, required 00070001", cfg_addr[1]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cfg_addr[1] !== 32'h0 || cfg_data[1] !== 32'h0 || bsy[1] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: addr=%h data=%h busy=%b, required 0/0/0",
               cfg_addr[1], cfg_data[1], bsy[1]);
    end
    @(negedge clk) rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (nrun[1] != 0 || bsy[1] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: writes=%0d busy=%b, required 0/0", nrun[1], bsy[1]);
    end
  endtask

`ifdef PE_CONFIG_SEQ_CHECKSUM_EN
  task automatic test_checksum();
    clear_log(0);
    pulse_start(0);
    wq = '{32'd1, 32'h0006_0001, 32'h0000_0003, 32'h0006_0003};
    feed(0, 1'b0);
    wait_idle(0);
    checks++;
    if (ndone[0] != 1 || err[0] !== 1'b0) begin
      errors++;
      $display("FAIL checksum_good: done=%0d error=%b, required 1/0", ndone[0], err[0]);
    end
    clear_log(0);
    pulse_start(0);
    wq = '{32'd1, 32'h0006_0001, 32'h0000_0003, 32'h0000_0000};
    feed(0, 1'b0);
    wait_idle(0);
    checks++;
    if (ndone[0] != 0 || err[0] !== 1'b1 || wd[0] !== 16'd1) begin
      errors++;
      $display("FAIL checksum_bad: done=%0d error=%b wd=%0d, required 0/1/1",
               ndone[0], err[0], wd[0]);
    end
  endtask
`endif

  initial begin
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0;
      vld[d] = 1'b0;
      din[d] = 32'h0;
      prev_addr[d] = 32'h0;
      nrun[d] = 0;
      ndone[d] = 0;
      rdy_bad[d] = 0;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_header();
    test_bad_addr();
    test_timeout();
    test_reset_mid_write();
`ifdef PE_CONFIG_SEQ_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
